// File: rtl/pt2262_encoder_gen_if.sv
// pt2262_encoder_gen_if: control/data bundle between a transmit controller and
// the PT2262-style encoder.
//   start   : request a transmission burst (controller -> encoder)
//   addr_01 : address level per trinary position
//   addr_f  : 1 = position floating (F), overrides addr_01
//   data    : binary data bits
//   busy    : burst in progress (encoder -> controller)
//   done    : one-cycle pulse at the end of the burst
//   sync    : high while the SYNC symbol is on the line
//   cod_o   : encoded serial output
interface pt2262_encoder_gen_if #(
  parameter int N_ADDR = 8,
  parameter int N_DATA = 4
);
  logic              start;
  logic [N_ADDR-1:0] addr_01;
  logic [N_ADDR-1:0] addr_f;
  logic [N_DATA-1:0] data;
  logic              busy;
  logic              done;
  logic              sync;
  logic              cod_o;

  modport master (
    output start, addr_01, addr_f, data,
    input  busy, done, sync, cod_o
  );

  modport slave (
    input  start, addr_01, addr_f, data,
    output busy, done, sync, cod_o
  );
endinterface

// File: rtl/pt2262_encoder_gen.sv
// pt2262_encoder_gen: parametrised PT2262-style remote-control encoder.
// Serialises N_ADDR trinary address positions (0/1/F) and N_DATA data bits,
// then a SYNC symbol; a start sends N_REPEAT back-to-back frames.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : pt2262_encoder_gen_if.slave (start/addr_01/addr_f/data in,
//           busy/done/sync/cod_o out)
// Optional build macro PT2262_CONT_EN: when defined, a start held high at the
// end of the last frame re-captures the inputs and keeps transmitting frames
// without a done pulse until start is seen low at a frame end.
module pt2262_encoder_gen #(
  parameter int N_ADDR   = 8,
  parameter int N_DATA   = 4,
  parameter int CLK_DIV  = 125,
  parameter int N_REPEAT = 4
) (
  input logic                 clk,
  input logic                 reset,
  pt2262_encoder_gen_if.slave bus
);
  localparam int NB      = N_ADDR + N_DATA;
  localparam int PRE_MAX = 2 * CLK_DIV - 1;
  localparam int PW      = $clog2(2 * CLK_DIV);
  localparam int BW      = $clog2(NB);
  localparam int FW      = (N_REPEAT > 1) ? $clog2(N_REPEAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BITS, S_SYNC, S_FINISH} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     pre, pre_n;
  logic [6:0]        t, t_n, t_inc;     // tick index inside symbol (SYNC needs 0..127)
  logic [BW-1:0]     bitc, bit_n;
  logic [FW-1:0]     frm, frm_n;
  logic              busy_q, busy_n, done_q, done_n, sync_q, sync_n, cod_q, cod_n;
  logic [N_ADDR-1:0] a01_s, a01_n, af_s, af_n;
  logic [N_DATA-1:0] d_s, d_n;
  logic              tick;
  logic [NB-1:0]     f_vec, v_vec;

  // Flattened symbol table: positions 0..N_ADDR-1 are address, then data.
  assign f_vec = {{N_DATA{1'b0}}, af_s};
  assign v_vec = {d_s, a01_s};
  assign tick  = (pre == PW'(PRE_MAX));

  // Every symbol is two 16-tick halves, each starting high for 4 or 12 ticks.
  // '0' is short/short, '1' long/long, 'F' short/long.
  function automatic logic sym_level(input logic is_f, input logic val,
                                     input logic [4:0] ti);
    logic wide;
    wide = is_f ? ti[4] : val;
    return wide ? (ti[3:0] < 4'd12) : (ti[3:0] < 4'd4);
  endfunction

  always_comb begin
    state_n = state;
    pre_n   = pre;
    t_n     = t;
    bit_n   = bitc;
    frm_n   = frm;
    busy_n  = busy_q;
    done_n  = 1'b0;
    sync_n  = sync_q;
    cod_n   = cod_q;
    a01_n   = a01_s;
    af_n    = af_s;
    d_n     = d_s;
    t_inc   = t + 7'd1;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          a01_n   = bus.addr_01;
          af_n    = bus.addr_f;
          d_n     = bus.data;
          pre_n   = '0;
          t_n     = '0;
          bit_n   = '0;
          frm_n   = '0;
          busy_n  = 1'b1;
          sync_n  = 1'b0;
          cod_n   = 1'b1;          // every symbol opens with a high phase
          state_n = S_BITS;
        end
      end
      S_BITS: begin
        pre_n = tick ? '0 : pre + 1'b1;
        if (tick) begin
          if (t == 7'd31) begin
            t_n   = '0;
            cod_n = 1'b1;
            if (bitc == BW'(NB - 1)) begin
              bit_n   = '0;
              sync_n  = 1'b1;
              state_n = S_SYNC;
            end else begin
              bit_n = bitc + 1'b1;
            end
          end else begin
            t_n   = t_inc;
            cod_n = sym_level(f_vec[bitc], v_vec[bitc], t_inc[4:0]);
          end
        end
      end
      S_SYNC: begin
        pre_n = tick ? '0 : pre + 1'b1;
        if (tick) begin
          if (t == 7'd127) begin
            t_n = '0;
            if (frm != FW'(N_REPEAT - 1)) begin
              frm_n   = frm + 1'b1;
              sync_n  = 1'b0;
              cod_n   = 1'b1;
              state_n = S_BITS;
            end
`ifdef PT2262_CONT_EN
            // Continuous mode: one more frame with freshly captured inputs;
            // frm stays on the last index so the check repeats next frame.
            else if (bus.start) begin
              a01_n   = bus.addr_01;
              af_n    = bus.addr_f;
              d_n     = bus.data;
              sync_n  = 1'b0;
              cod_n   = 1'b1;
              state_n = S_BITS;
            end
`endif
            else begin
              frm_n   = '0;
              pre_n   = '0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
              sync_n  = 1'b0;
              cod_n   = 1'b0;
              state_n = S_FINISH;
            end
          end else begin
            t_n   = t_inc;
            cod_n = (t_inc < 7'd4);
          end
        end
      end
      S_FINISH: state_n = S_IDLE;   // start is not sampled here
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      pre    <= '0;
      t      <= '0;
      bitc   <= '0;
      frm    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sync_q <= 1'b0;
      cod_q  <= 1'b0;
      a01_s  <= '0;
      af_s   <= '0;
      d_s    <= '0;
    end else begin
      state  <= state_n;
      pre    <= pre_n;
      t      <= t_n;
      bitc   <= bit_n;
      frm    <= frm_n;
      busy_q <= busy_n;
      done_q <= done_n;
      sync_q <= sync_n;
      cod_q  <= cod_n;
      a01_s  <= a01_n;
      af_s   <= af_n;
      d_s    <= d_n;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sync  = sync_q;
  assign bus.cod_o = cod_q;
endmodule

// File: tb/tb_pt2262_encoder_gen.sv
// Bench for pt2262_encoder_gen: two instances (N_REPEAT=1 and N_REPEAT=3,
// CLK_DIV=2) compared every clk against a waveform model derived from the
// symbol timing rules. Honours PT2262_CONT_EN when defined.
module tb_pt2262_encoder_gen;
  localparam int NA = 8, ND = 4, CD = 2;
  localparam int TCK = 2 * CD, NB = NA + ND;
  localparam int FRAME_T = 32 * NB + 128;
  localparam int FR = FRAME_T * TCK;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pt2262_encoder_gen_if #(.N_ADDR(NA), .N_DATA(ND)) ia ();
  pt2262_encoder_gen_if #(.N_ADDR(NA), .N_DATA(ND)) ib ();

  pt2262_encoder_gen #(.N_ADDR(NA), .N_DATA(ND), .CLK_DIV(CD), .N_REPEAT(1))
    dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
  pt2262_encoder_gen #(.N_ADDR(NA), .N_DATA(ND), .CLK_DIV(CD), .N_REPEAT(3))
    dut_b (.clk(clk), .reset(reset), .bus(ib.slave));

  // Per-frame values the model expects to see transmitted.
  logic [NA-1:0] m_a01 [3];
  logic [NA-1:0] m_af  [3];
  logic [ND-1:0] m_d   [3];

  // Expected {cod_o, sync, busy, done} at clk offset c after the acceptance edge.
  function automatic logic [3:0] exp_vec(int c, int nfr);
    int total, tk, fr, ft, t, s;
    logic is_f, val, hi;
    total = nfr * FR;
    if (c > total)  return 4'b0000;
    if (c == total) return 4'b0001;
    tk = c / TCK;
    fr = tk / FRAME_T;
    ft = tk % FRAME_T;
    if (ft >= 32 * NB) begin
      t = ft - 32 * NB;
      return {(t < 4), 1'b1, 1'b1, 1'b0};
    end
    s = ft / 32;
    t = ft % 32;
    if (s < NA) begin
      is_f = m_af[fr][s];
      val  = m_a01[fr][s];
    end else begin
      is_f = 1'b0;
      val  = m_d[fr][s - NA];
    end
    if (is_f)     hi = (t < 4)  || (t >= 16 && t < 28);
    else if (val) hi = (t < 12) || (t >= 16 && t < 28);
    else          hi = (t < 4)  || (t >= 16 && t < 20);
    return {hi, 1'b0, 1'b1, 1'b0};
  endfunction

  function automatic logic [3:0] obs(bit sel);
    return sel ? {ib.cod_o, ib.sync, ib.busy, ib.done}
               : {ia.cod_o, ia.sync, ia.busy, ia.done};
  endfunction

  task automatic rand_frame(int f);
    m_a01[f] = NA'($urandom);
    m_af[f]  = NA'($urandom);
    m_d[f]   = ND'($urandom);
  endtask

  task automatic apply(bit sel, logic st, int f);
    if (sel) begin
      ib.start = st; ib.addr_01 = m_a01[f]; ib.addr_f = m_af[f]; ib.data = m_d[f];
    end else begin
      ia.start = st; ia.addr_01 = m_a01[f]; ia.addr_f = m_af[f]; ia.data = m_d[f];
    end
  endtask

  // Called at a negedge; returns at the negedge following the acceptance edge.
  task automatic launch(bit sel, bit hold);
    apply(sel, 1'b1, 0);
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      if (sel) ib.start = 1'b0; else ia.start = 1'b0;
    end
  endtask

  task automatic test_reset;
    ia.start = 0; ia.addr_01 = '0; ia.addr_f = '0; ia.data = '0;
    ib.start = 0; ib.addr_01 = '0; ib.addr_f = '0; ib.data = '0;
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs(0) !== 4'b0000) begin n_fail++; $display("FAIL reset_a got=%b want=0000", obs(0)); end
      n_checks++;
      if (obs(1) !== 4'b0000) begin n_fail++; $display("FAIL reset_b got=%b want=0000", obs(1)); end
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_zero;
    m_a01[0] = '0; m_af[0] = '0; m_d[0] = '0;
    launch(0, 0);
    for (int c = 0; c <= FR + 1; c++) begin
      n_checks++;
      if (obs(0) !== exp_vec(c, 1)) begin
        n_fail++; $display("FAIL frame_zero c=%0d got=%b want=%b", c, obs(0), exp_vec(c, 1));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_addr_f;
    for (int r = 0; r < 2; r++) begin
      rand_frame(0);
      if (r == 0) begin m_a01[0] = 8'h01; m_af[0] = 8'h02; end
      launch(0, 0);
      for (int c = 0; c <= FR + 1; c++) begin
        n_checks++;
        if (obs(0) !== exp_vec(c, 1)) begin
          n_fail++; $display("FAIL addr_f r=%0d c=%0d got=%b want=%b", r, c, obs(0), exp_vec(c, 1));
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_repeat;
    rand_frame(0);
    m_d[0] = 4'hA;
    for (int f = 1; f < 3; f++) begin
      m_a01[f] = m_a01[0]; m_af[f] = m_af[0]; m_d[f] = m_d[0];
    end
    launch(1, 0);
    for (int c = 0; c <= 3 * FR + 3; c++) begin
      n_checks++;
      if (obs(1) !== exp_vec(c, 3)) begin
        n_fail++; $display("FAIL repeat c=%0d got=%b want=%b", c, obs(1), exp_vec(c, 3));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_capture;
    rand_frame(0);
    launch(0, 0);
    for (int c = 0; c <= FR + 1; c++) begin
      n_checks++;
      if (obs(0) !== exp_vec(c, 1)) begin
        n_fail++; $display("FAIL capture c=%0d got=%b want=%b", c, obs(0), exp_vec(c, 1));
      end
      if (c < FR - 1) begin
        ia.addr_01 = NA'($urandom); ia.addr_f = NA'($urandom); ia.data = ND'($urandom);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort_reset;
    int off;
    off = (5 * 32 + 10) * TCK + 1;
    rand_frame(0);
    launch(0, 0);
    for (int c = 0; c < off; c++) begin
      n_checks++;
      if (obs(0) !== exp_vec(c, 1)) begin
        n_fail++; $display("FAIL abort_pre c=%0d got=%b want=%b", c, obs(0), exp_vec(c, 1));
      end
      @(negedge clk);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (obs(0) !== 4'b0000) begin n_fail++; $display("FAIL abort_async got=%b want=0000", obs(0)); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs(0) !== 4'b0000) begin n_fail++; $display("FAIL abort_hold i=%0d got=%b want=0000", i, obs(0)); end
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs(0) !== 4'b0000) begin n_fail++; $display("FAIL abort_release got=%b want=0000", obs(0)); end
    rand_frame(0);
    launch(0, 0);
    for (int c = 0; c <= FR + 1; c++) begin
      n_checks++;
      if (obs(0) !== exp_vec(c, 1)) begin
        n_fail++; $display("FAIL abort_fresh c=%0d got=%b want=%b", c, obs(0), exp_vec(c, 1));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_cont;
    int nfr;
`ifdef PT2262_CONT_EN
    nfr = 3;
`else
    nfr = 1;
`endif
    for (int f = 0; f < 3; f++) rand_frame(f);
    launch(0, 1);
    for (int c = 0; c <= nfr * FR + 4; c++) begin
      n_checks++;
      if (obs(0) !== exp_vec(c, nfr)) begin
        n_fail++; $display("FAIL cont c=%0d got=%b want=%b", c, obs(0), exp_vec(c, nfr));
      end
      if (nfr == 3) begin
        if (c == FR / 2)          apply(0, 1'b1, 1);
        if (c == FR + FR / 2)     apply(0, 1'b1, 2);
        if (c == 2 * FR + FR / 2) ia.start = 1'b0;
      end else begin
        // Held start and input changes must not disturb the single frame.
        if (c == FR / 2) apply(0, 1'b1, 1);
        if (c == FR + 1) ia.start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_frame_zero();
    test_addr_f();
    test_repeat();
    test_capture();
    test_abort_reset();
    test_cont();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pt2262_encoder_gen.md
Name: pt2262_encoder_gen

Overview:
Parametrised PT2262-style remote-control encoder, the successor to the fixed 8-address/4-data encoder. It derives the oscillator timebase from clk, serialises trinary address bits (0/1/F) and binary data bits, then appends a SYNC symbol. Each transmission is a start-triggered burst of N_REPEAT frames, with a busy/done handshake toward the controlling logic.

Parameters:
N_ADDR, 8, number of trinary address positions (1..16)
N_DATA, 4, number of binary data bits (1..8)
CLK_DIV, 125, clk cycles per oscillator half-period; one osc tick = 2*CLK_DIV clk cycles (min 1)
N_REPEAT, 4, frames sent per start (1..255)

Ports:
clk  input  1  system clock (3 MHz nominal)
reset  input  1  asynchronous, active-high reset
start  input  1  request transmission; sampled only in IDLE
addr_01  input  N_ADDR  address level per position (0/1)
addr_f  input  N_ADDR  1 = position floating (F), overrides addr_01
data  input  N_DATA  data bits
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle pulse at end of the last frame
sync  output  1  high while the SYNC symbol is being emitted
cod_o  output  1  encoded serial output

Behaviour:
- Single clk domain. No derived clocks: the prescaler produces a tick enable every 2*CLK_DIV clk cycles.
- Reset (async): state IDLE; busy=0, done=0, sync=0, cod_o=0; prescaler, tick, bit and frame counters = 0. Reset asserted mid-frame aborts immediately, with no done pulse.
- FSM states: IDLE -> BITS -> SYNC -> (BITS for the next frame | FINISH) -> IDLE.
- IDLE: start=1 at clk edge k captures addr_01, addr_f and data into shadow registers, and clears the prescaler and counters. At edge k+1: busy=1, state BITS, cod_o=1 (first high phase). Input changes while busy are ignored until the next start.
- Bit order per frame: address positions 0..N_ADDR-1, then data bits 0..N_DATA-1, then SYNC.
- Each bit spans 32 ticks (tick index t=0..31):
  - '0': high for t 0-3, low 4-15, high 16-19, low 20-31.
  - '1': high 0-11, low 12-15, high 16-27, low 28-31.
  - 'F': high 0-3, low 4-15, high 16-27, low 28-31.
- Address position i is F if addr_f[i]=1, else addr_01[i]. Data bits are 0 or 1 only.
- SYNC spans 128 ticks: cod_o high for t 0-3, low for 4-127. sync=1 for all 128 ticks and 0 otherwise.
- Frame length = 32*(N_ADDR+N_DATA)+128 ticks. Frames follow back-to-back with no gap, reusing the same captured values.
- After SYNC of frame N_REPEAT-1, at the cycle the final tick expires: state FINISH, done=1 for one cycle, busy=0, cod_o=0, sync=0. Next cycle: IDLE, done=0.
- start held high through FINISH is not accepted until IDLE. A new start is accepted no earlier than the cycle after done.
- cod_o is registered and changes only on tick boundaries (or at the acceptance edge).
- Counter widths are sized with $clog2 from the parameters. No wrap occurs inside a frame.

Optional Feature:
PT2262_CONT_EN:
- Defined: at the end of frame N_REPEAT-1, if start=1, the block re-captures addr_01, addr_f and data and starts another frame immediately, with no gap and no done pulse. This repeats while start stays high. done is issued after the first final-SYNC with start=0.
- Undefined: exactly N_REPEAT frames per start, and start is ignored while busy.

Test Plan:
1. CLK_DIV=2, N_REPEAT=1, addr_f=0, addr_01=8'h00, data=4'h0, pulse start -> busy at next edge; each bit is cod_o high 16 clk, low 48, high 16, low 48; sync high for 512 clk; done pulse at clk 4*(12*32+128)=2048 after acceptance.
2. addr_01=8'h01, addr_f=8'h02 -> position 0 shows 48H/16L/48H/16L (clk, CLK_DIV=2); position 1 (F) shows 16H/48L/48H/16L.
3. N_REPEAT=3, data=4'hA -> three identical frames back-to-back, a single done pulse, busy low exactly 1 cycle after the third SYNC ends.
4. Change addr_01 and data while busy -> transmitted bits still match the values captured at start.
5. Assert reset at tick 10 of bit 5 -> cod_o, busy, sync drop to 0 asynchronously, no done; after release, a new start gives a full fresh frame.
6. With PT2262_CONT_EN, N_REPEAT=1, hold start high for 2.5 frames then release -> 3 frames emitted, one done at the end of the third; without the macro -> 1 frame and one done.
